// File: rtl/signed_seg_display.sv
// Signed/unsigned binary to multiplexed seven-segment display driver.
// Sequential double-dabble conversion with sign, leading-zero blanking and overflow dashes.
module signed_seg_display #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] value,
  input  logic              signed_mode,
  input  logic              value_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [0:6]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_ABS, S_SHIFT, S_FIN} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [DATA_W-1:0]          r_value;
  logic                       r_sm;
  logic                       r_neg;
  logic [DATA_W-1:0]          r_mag;
  logic [BCD_W-1:0]           r_bcd;
  logic [SH_W-1:0]            r_sh_cnt;
  logic                       r_ovf_sticky;
  logic [DIGITS-1:0][0:6]     r_disp;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_overflow;
  logic [CNT_W-1:0]           r_ref_cnt;
  logic [IDX_W-1:0]           r_idx;
  logic [0:6]                 r_seg;
  logic [DIGITS-1:0]          r_an;

  logic                       w_neg_abs;
  logic [DATA_W-1:0]          w_mag_abs;
  logic [BCD_W-1:0]           w_bcd_adj;
  logic                       w_ovf_fin;
  logic [IDX_W-1:0]           w_msd;
  logic [DIGITS-1:0][0:6]     w_disp_fin;

  function automatic logic [0:6] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (value_valid) w_state_nxt = S_ABS;
      S_ABS:   w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_sh_cnt == SH_W'(DATA_W - 1)) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: magnitude, BCD correction and final display image.
  always_comb begin
    w_neg_abs = r_sm & r_value[DATA_W-1];
    w_mag_abs = w_neg_abs ? (DATA_W'(0) - r_value) : r_value;

    w_bcd_adj = r_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end

    w_ovf_fin = r_ovf_sticky | (r_neg & (r_bcd[BCD_W-1 -: 4] != 4'd0));

    w_msd = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_msd = IDX_W'(i);
    end

    w_disp_fin = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_ovf_fin)                             w_disp_fin[i] = SEG_DASH;
      else if (i <= int'(w_msd))                 w_disp_fin[i] = seg_code(r_bcd[4*i +: 4]);
      else if (r_neg && (i == int'(w_msd) + 1))  w_disp_fin[i] = SEG_DASH;
      else                                       w_disp_fin[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value      <= '0;
      r_sm         <= 1'b0;
      r_neg        <= 1'b0;
      r_mag        <= '0;
      r_bcd        <= '0;
      r_sh_cnt     <= '0;
      r_ovf_sticky <= 1'b0;
      r_disp       <= '1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE);
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (value_valid) begin
            r_value <= value;
            r_sm    <= signed_mode;
          end
        end
        S_ABS: begin
          r_neg        <= w_neg_abs;
          r_mag        <= w_mag_abs;
          r_bcd        <= '0;
          r_ovf_sticky <= 1'b0;
          r_sh_cnt     <= '0;
        end
        S_SHIFT: begin
          r_bcd    <= {w_bcd_adj[BCD_W-2:0], r_mag[DATA_W-1]};
          r_mag    <= {r_mag[DATA_W-2:0], 1'b0};
          r_sh_cnt <= r_sh_cnt + SH_W'(1);
          if (w_bcd_adj[BCD_W-1]) r_ovf_sticky <= 1'b1;
        end
        S_FIN: begin
          r_disp     <= w_disp_fin;
          r_overflow <= w_ovf_fin;
        end
        default: ;
      endcase
    end
  end

  // Digit scan runs free of the converter; display image only changes in FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt <= '0;
      r_idx     <= '0;
      r_seg     <= SEG_BLANK;
      r_an      <= '1;
    end else begin
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_seg <= r_disp[r_idx];
      if (r_ref_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        r_ref_cnt <= '0;
        r_idx     <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_ref_cnt <= r_ref_cnt + CNT_W'(1);
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign seg      = r_seg;
  assign an       = r_an;

endmodule

// File: tb/tb_signed_seg_display.sv
// Bench for signed_seg_display: 8-bit and 16-bit instances, 4 digits, 4-cycle refresh,
// checked against a decimal-arithmetic reference model.
module tb_signed_seg_display;

  logic        clk;
  logic        rst_n;

  logic [7:0]  v8;
  logic        sm8, vv8, busy8, done8, ovf8;
  logic [0:6]  seg8;
  logic [3:0]  an8;

  logic [15:0] v16;
  logic        sm16, vv16, busy16, done16, ovf16;
  logic [0:6]  seg16;
  logic [3:0]  an16;

  int checks = 0;
  int errors = 0;

  logic [7:0] bv  [5];
  logic       bsm [5];

  signed_seg_display #(.DATA_W(8), .DIGITS(4), .REFRESH_DIV(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .value(v8), .signed_mode(sm8), .value_valid(vv8),
    .busy(busy8), .done(done8), .overflow(ovf8), .seg(seg8), .an(an8)
  );

  signed_seg_display #(.DATA_W(16), .DIGITS(4), .REFRESH_DIV(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .value(v16), .signed_mode(sm16), .value_valid(vv16),
    .busy(busy16), .done(done16), .overflow(ovf16), .seg(seg16), .an(an16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:6] digit_seg(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Reference: interpret value as an integer, count decimal digits, lay out the text.
  function automatic void ref_num(input logic [15:0] val, input bit sm, input int w,
                                  output bit neg, output longint mag, output int nd);
    longint v, p;
    v = longint'(val);
    if (sm && val[w-1]) v = v - (longint'(1) << w);
    neg = (v < 0);
    mag = neg ? -v : v;
    nd  = 1;
    p   = 10;
    while (mag >= p) begin
      nd++;
      p = p * 10;
    end
  endfunction

  function automatic bit exp_ovf(input logic [15:0] val, input bit sm, input int w);
    bit neg; longint mag; int nd;
    ref_num(val, sm, w, neg, mag, nd);
    return (nd + int'(neg)) > 4;
  endfunction

  function automatic logic [0:6] exp_code(input logic [15:0] val, input bit sm, input int w,
                                          input int k);
    bit neg; longint mag, p; int nd;
    ref_num(val, sm, w, neg, mag, nd);
    if ((nd + int'(neg)) > 4) return 7'b1111110;
    if (k < nd) begin
      p = 1;
      repeat (k) p = p * 10;
      return digit_seg(int'((mag / p) % 10));
    end
    if (neg && k == nd) return 7'b1111110;
    return 7'b1111111;
  endfunction

  task automatic drive(input int which, input bit vv, input logic [15:0] v, input bit sm);
    if (which == 0) begin
      vv8 = vv; v8 = v[7:0]; sm8 = sm;
    end else begin
      vv16 = vv; v16 = v; sm16 = sm;
    end
  endtask

  // Collect one full scan frame; each digit is recorded when its enable is active.
  task automatic read_disp(input int which, output logic [3:0][6:0] d);
    logic [0:6] s;
    logic [3:0] a, sel;
    d = 'x;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      s = (which != 0) ? seg16 : seg8;
      a = (which != 0) ? an16 : an8;
      for (int k = 0; k < 4; k++) begin
        sel = ~(4'b0001 << k);
        if (a == sel) d[k] = s;
      end
    end
  endtask

  task automatic run_conv(input int which, input logic [15:0] v, input bit sm,
                          input bit pulse_mid, input string tag);
    int w, lat;
    logic dn, ov;
    logic [3:0][6:0] d;
    w   = (which != 0) ? 16 : 8;
    lat = 0;
    @(negedge clk);
    drive(which, 1'b1, v, sm);
    @(posedge clk); #1;
    drive(which, 1'b0, v, sm);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (pulse_mid && n == 3) drive(which, 1'b1, 16'h0005, 1'b0);
      if (pulse_mid && n == 4) drive(which, 1'b0, 16'h0005, 1'b0);
      dn = (which != 0) ? done16 : done8;
      if (dn) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, lat, w + 2);
    ov = (which != 0) ? ovf16 : ovf8;
    check({tag, " overflow"}, ov, exp_ovf(v, sm, w));
    read_disp(which, d);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s digit%0d", tag, k), d[k], exp_code(v, sm, w, k));
  endtask

  initial begin
    logic [3:0] ea;
    int idx;
    logic [3:0] sel;

    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0000, 1'b0);
    drive(1, 1'b0, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset busy8", busy8, 1'b0);
    check("reset done8", done8, 1'b0);
    check("reset ovf8", ovf8, 1'b0);
    check("reset seg8", seg8, 7'b1111111);
    check("reset an8", an8, 4'b1111);
    check("reset an16", an16, 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;

    run_conv(0, 16'h00FE, 1'b1, 1'b0, "fe_signed");

    // Reset in the middle of a conversion
    @(negedge clk);
    drive(0, 1'b1, 16'h0080, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0080, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset busy8", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset busy8", busy8, 1'b0);
    check("midreset done8", done8, 1'b0);
    check("midreset seg8", seg8, 7'b1111111);
    check("midreset an8", an8, 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk); #1;
      ea = ~(4'b0001 << (((e - 1) / 4) % 4));
      check($sformatf("scan an e=%0d", e), an8, ea);
      check($sformatf("scan seg blank e=%0d", e), seg8, 7'b1111111);
    end

    run_conv(0, 16'h0080, 1'b1, 1'b0, "80_signed");
    run_conv(0, 16'h0080, 1'b0, 1'b0, "80_unsigned");
    run_conv(0, 16'h0000, 1'b0, 1'b1, "zero_ignored");
    run_conv(0, 16'h00FF, 1'b1, 1'b0, "ff_signed");
    run_conv(0, 16'h00FF, 1'b0, 1'b0, "ff_unsigned");

    run_conv(1, 16'd10000, 1'b0, 1'b0, "w16_10000");
    run_conv(1, 16'hFC18, 1'b1, 1'b0, "w16_m1000");
    run_conv(1, 16'hFC19, 1'b1, 1'b0, "w16_m999");
    run_conv(1, 16'd9999, 1'b0, 1'b0, "w16_9999");

    for (int r = 0; r < 6; r++) begin
      run_conv(0, {8'h00, 8'($urandom)}, 1'($urandom_range(0, 1)), 1'b0,
               $sformatf("rand8_%0d", r));
      run_conv(1, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b0,
               $sformatf("rand16_%0d", r));
      run_conv(1, 16'($urandom_range(0, 12000)), 1'($urandom_range(0, 1)), 1'b0,
               $sformatf("rand16s_%0d", r));
    end

    // Back-to-back captures with value_valid held high
    for (int i = 0; i < 5; i++) begin
      bv[i]  = 8'($urandom);
      bsm[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    v8 = bv[0]; sm8 = bsm[0]; vv8 = 1'b1;
    for (int t = 0; t <= 54; t++) begin
      @(posedge clk); #1;
      if ((t % 11 == 0) && (t / 11 < 4)) begin
        v8  = bv[t / 11 + 1];
        sm8 = bsm[t / 11 + 1];
      end
      if (t == 54) vv8 = 1'b0;
      check($sformatf("b2b done t=%0d", t), done8, (t % 11 == 10));
      if (t >= 11) begin
        idx = -1;
        for (int k = 0; k < 4; k++) begin
          sel = ~(4'b0001 << k);
          if (an8 == sel) idx = k;
        end
        check($sformatf("b2b an onehot t=%0d", t), (idx >= 0), 1'b1);
        if (idx >= 0)
          check($sformatf("b2b seg t=%0d", t), seg8,
                exp_code({8'h00, bv[(t - 11) / 11]}, bsm[(t - 11) / 11], 8, idx));
      end
    end
    repeat (20) @(posedge clk);
    #1;
    check("final busy8", busy8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_seg_display.md
# signed_seg_display

Parametrised signed/unsigned binary-to-seven-segment display driver. Successor to the fixed 4-digit ALU result decoder, placed between a datapath result (ALU output or any DATA_W-bit value) and the board's multiplexed common-anode display. Captures a value on a valid strobe and converts it to BCD with a sequential double-dabble engine. Adds sign, leading-zero blanking and overflow indication, then scans DIGITS digits with a programmable refresh rate.

## Interface
- DATA_W, 8, width of input value (>= 2)
- DIGITS, 4, number of display digits (1..8)
- REFRESH_DIV, 100000, clock cycles each digit stays enabled (>= 1)
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- value  input  DATA_W  number to display
- signed_mode  input  1  1: value is two's complement; 0: unsigned; sampled with value
- value_valid  input  1  capture request; honoured only when busy=0
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse: display registers updated
- overflow  output  1  currently displayed value did not fit
- seg  output  [0:6]  segments a..g (seg[0]=a), active-low
- an  output  DIGITS  digit enables, active-low one-hot, an[0] = rightmost digit

## Operation
- FSM states: IDLE, ABS, SHIFT, FIN.
- IDLE: when value_valid=1, latch value and signed_mode, then go to ABS. busy=1 from the next cycle.
- ABS: neg = signed_mode & value[DATA_W-1]; mag = neg ? -value : value, held as DATA_W-bit unsigned, so -2^(DATA_W-1) yields 2^(DATA_W-1). Clear the BCD register (4*DIGITS bits) and the ovf_sticky flag, then go to SHIFT.
- SHIFT: runs exactly DATA_W cycles. Each cycle:
  - add 3 to every BCD nibble >= 5;
  - shift {bcd, mag} left 1;
  - if the bit leaving the top nibble is 1, set ovf_sticky.
- FIN: one cycle. ovf = ovf_sticky | (neg & top nibble != 0), because a negative value needs one digit position for the sign. Latch the display registers, pulse done, return to IDLE.
- Display contents, in priority order:
  - ovf=1: every digit shows '-' and overflow=1.
  - Otherwise: digits from the most significant nonzero nibble down to digit 0 show their decimal values. Digit 0 always shows, so zero displays as "0". Leading zeros are blank. If neg, the digit immediately left of the most significant shown digit shows '-'. overflow=0.
- Segment codes (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - '-'=1111110, blank=1111111
- value_valid while busy=1 is ignored; there is no queue. Display registers change only in FIN, so the display never shows a partial result.
- Scan: refresh counter counts 0..REFRESH_DIV-1. At wrap, the digit index advances 0..DIGITS-1, then back to 0. an and seg are registered from the index and the display registers.

## Timing
- Reset (asynchronous, any state, including mid-conversion):
  - FSM goes to IDLE; busy=0, done=0, overflow=0.
  - Display registers go blank; seg=1111111; an all ones.
  - Refresh counter and digit index go to 0.
- First clock edge after reset release: an drives digit 0 (~1) with the blank code.
- Latency: value_valid sampled high at edge 0 in IDLE. busy=1 at edges 1..DATA_W+2. done=1 and new display/overflow values at edge DATA_W+2. busy=0 at edge DATA_W+3, when a new capture may be accepted.
- A value_valid held high continuously is recaptured every DATA_W+3 cycles.
- Each digit stays enabled for exactly REFRESH_DIV cycles. The full frame is DIGITS*REFRESH_DIV cycles.
- A display update changes seg on the next edge. There is no effect on scan phase.
- REFRESH_DIV=1: the digit advances every cycle.

## Test plan
- Reset checks (defaults, REFRESH_DIV=4 throughout):
  - assert rst_n=0 mid-SHIFT -> busy=0, seg=1111111, an=1111 immediately;
  - after release -> an steps 1110,1101,1011,0111 every 4 cycles, then repeats 1110.
- value=8'hFE, signed_mode=1 -> done exactly 10 cycles after capture; display "  -2":
  - digit0=0010010, digit1=1111110, digits 2-3 blank;
  - overflow=0.
- value=8'h80:
  - signed_mode=1 -> "-128" (digit3='-');
  - signed_mode=0 -> " 128" (digit3 blank).
- Zero and ignored capture: value=0 -> "   0". Then pulse value_valid with 8'h05 while busy -> ignored, display still "   0" after that conversion.
- Overflow, DATA_W=16, DIGITS=4:
  - value=16'd10000, unsigned -> all digits '-', overflow=1;
  - 16'hFC18 signed (-1000) -> all '-', overflow=1;
  - 16'hFC19 signed (-999) -> "-999", overflow=0.
- Back-to-back: hold value_valid=1 and change value each capture -> done every 11 cycles. Each displayed result matches the value latched at its capture edge.
